// File: rtl/sar_avg_decim.sv
// Averaging decimator behind sar_logic: sums 2^N SAR results, rounds half-up,
// and hands each average to a valid/ready consumer, flagging dropped results.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   cfg_en, cfg_log2n       enable / abort, window exponent (clamped)
//   sar_valid, sar_data     one-cycle conversion strobe and result
//   out_valid, out_ready    output handshake; out_data is the average
//   out_overrun, ovr_clr    sticky drop flag and its clear pulse
//   win_cnt                 samples accumulated in the current window
module sar_avg_decim #(
    parameter int DATA_W       = 10,
    parameter int LOG2_AVG_MAX = 4
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    cfg_en,
    input  logic [2:0]              cfg_log2n,
    input  logic                    sar_valid,
    input  logic [DATA_W-1:0]       sar_data,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_overrun,
    input  logic                    ovr_clr,
    output logic [LOG2_AVG_MAX:0]   win_cnt
);

    localparam int ACC_W = DATA_W + LOG2_AVG_MAX;
    localparam int CNT_W = LOG2_AVG_MAX + 1;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [2:0]         n_lat;

    logic [2:0]         n_cfg;
    logic [ACC_W-1:0]   acc_sum;
    logic [ACC_W-1:0]   rnd;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   target;
    logic               close;
    logic [DATA_W-1:0]  result;

    always_comb begin
        n_cfg    = (cfg_log2n > 3'(LOG2_AVG_MAX)) ? 3'(LOG2_AVG_MAX) : cfg_log2n;
        acc_sum  = acc + ACC_W'(sar_data);
        cnt_next = win_cnt + CNT_W'(1);
        target   = CNT_W'(1) << n_lat;
        // The sample that brings the count to 2^n_lat closes the window.
        close    = (state == ACCUM) && cfg_en && sar_valid && (cnt_next == target);
        // Half an LSB of the shifted result gives round-half-up.
        rnd      = (n_lat == 3'd0) ? '0 : (ACC_W'(1) << (n_lat - 3'd1));
        result   = DATA_W'((acc_sum + rnd) >> n_lat);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            acc         <= '0;
            win_cnt     <= '0;
            n_lat       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_en) begin
                        state   <= ACCUM;
                        n_lat   <= n_cfg;
                        acc     <= '0;
                        win_cnt <= '0;
                    end
                end
                ACCUM: begin
                    if (!cfg_en) begin
                        state   <= IDLE;
                        acc     <= '0;
                        win_cnt <= '0;
                    end else if (sar_valid) begin
                        if (close) begin
                            acc     <= '0;
                            win_cnt <= '0;
                            // New exponent applies from the next window only.
                            n_lat   <= n_cfg;
                        end else begin
                            acc     <= acc_sum;
                            win_cnt <= cnt_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // A consumer taking the old word frees the slot in the same cycle.
            if (close && (!out_valid || out_ready)) begin
                out_data  <= result;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // Setting wins over a simultaneous clear.
            if (close && out_valid && !out_ready) begin
                out_overrun <= 1'b1;
            end else if (ovr_clr) begin
                out_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sar_avg_decim.sv
// Directed testbench for sar_avg_decim: passthrough, rounding, clamping,
// overrun, back-to-back handshake, abort and mid-window reset.
module tb_sar_avg_decim;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_en;
    logic [2:0] cfg_log2n;
    logic       sar_valid;
    logic [9:0] sar_data;
    logic       out_ready;
    logic       out_valid;
    logic [9:0] out_data;
    logic       out_overrun;
    logic       ovr_clr;
    logic [4:0] win_cnt;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    sar_avg_decim dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cfg_en      (cfg_en),
        .cfg_log2n   (cfg_log2n),
        .sar_valid   (sar_valid),
        .sar_data    (sar_data),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_overrun (out_overrun),
        .ovr_clr     (ovr_clr),
        .win_cnt     (win_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] d);
        sar_valid = 1'b1;
        sar_data  = d;
        tick();
        sar_valid = 1'b0;
    endtask

    task automatic start(input logic [2:0] n);
        cfg_en = 1'b0;
        tick();
        cfg_log2n = n;
        cfg_en    = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL reset_valid got %b want 0", out_valid); fails++;
        end
        checks++;
        if (out_data !== 10'd0) begin
            $display("FAIL reset_data got %0d want 0", out_data); fails++;
        end
        checks++;
        if (out_overrun !== 1'b0) begin
            $display("FAIL reset_ovr got %b want 0", out_overrun); fails++;
        end
        checks++;
        if (win_cnt !== 5'd0) begin
            $display("FAIL reset_cnt got %0d want 0", win_cnt); fails++;
        end
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        logic [9:0] v [3] = '{10'd5, 10'd1023, 10'd0};
        out_ready = 1'b1;
        start(3'd0);
        for (int i = 0; i < 3; i++) begin
            send(v[i]);
            checks++;
            if (out_valid !== 1'b1 || out_data !== v[i]) begin
                $display("FAIL pass%0d got v=%b d=%0d want v=1 d=%0d",
                         i, out_valid, out_data, v[i]);
                fails++;
            end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL pass_drain got %b want 0", out_valid); fails++;
        end
    endtask

    task automatic test_round();
        out_ready = 1'b1;
        start(3'd2);
        send(10'd1); send(10'd2); send(10'd3);
        checks++;
        if (win_cnt !== 5'd3 || out_valid !== 1'b0) begin
            $display("FAIL rnd_partial got cnt=%0d v=%b want cnt=3 v=0",
                     win_cnt, out_valid);
            fails++;
        end
        send(10'd4);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'd3 || win_cnt !== 5'd0) begin
            $display("FAIL rnd_1234 got v=%b d=%0d cnt=%0d want v=1 d=3 cnt=0",
                     out_valid, out_data, win_cnt);
            fails++;
        end
        send(10'd1); send(10'd1); send(10'd1); send(10'd2);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'd1) begin
            $display("FAIL rnd_1112 got v=%b d=%0d want v=1 d=1",
                     out_valid, out_data);
            fails++;
        end
    endtask

    task automatic test_clamp_max();
        out_ready = 1'b1;
        start(3'd7);
        for (int i = 0; i < 15; i++) send(10'd1023);
        checks++;
        if (win_cnt !== 5'd15 || out_valid !== 1'b0) begin
            $display("FAIL max_partial got cnt=%0d v=%b want cnt=15 v=0",
                     win_cnt, out_valid);
            fails++;
        end
        send(10'd1023);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'd1023 || win_cnt !== 5'd0) begin
            $display("FAIL max_full got v=%b d=%0d cnt=%0d want v=1 d=1023 cnt=0",
                     out_valid, out_data, win_cnt);
            fails++;
        end
    endtask

    task automatic test_overrun();
        out_ready = 1'b1;
        start(3'd1);
        out_ready = 1'b0;
        send(10'd10); send(10'd20);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'd15 || out_overrun !== 1'b0) begin
            $display("FAIL ovr_first got v=%b d=%0d o=%b want v=1 d=15 o=0",
                     out_valid, out_data, out_overrun);
            fails++;
        end
        send(10'd30); send(10'd40);
        checks++;
        if (out_data !== 10'd15 || out_overrun !== 1'b1) begin
            $display("FAIL ovr_drop got d=%0d o=%b want d=15 o=1",
                     out_data, out_overrun);
            fails++;
        end
        send(10'd50);
        ovr_clr = 1'b1;
        send(10'd60);
        ovr_clr = 1'b0;
        checks++;
        if (out_overrun !== 1'b1 || out_data !== 10'd15) begin
            $display("FAIL ovr_setwins got o=%b d=%0d want o=1 d=15",
                     out_overrun, out_data);
            fails++;
        end
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        checks++;
        if (out_overrun !== 1'b0 || out_valid !== 1'b1) begin
            $display("FAIL ovr_clr got o=%b v=%b want o=0 v=1",
                     out_overrun, out_valid);
            fails++;
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL ovr_consume got v=%b want 0", out_valid); fails++;
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        start(3'd1);
        out_ready = 1'b0;
        send(10'd2); send(10'd4);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'd3) begin
            $display("FAIL b2b_first got v=%b d=%0d want v=1 d=3",
                     out_valid, out_data);
            fails++;
        end
        send(10'd6);
        out_ready = 1'b1;
        send(10'd8);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'd7 || out_overrun !== 1'b0) begin
            $display("FAIL b2b_second got v=%b d=%0d o=%b want v=1 d=7 o=0",
                     out_valid, out_data, out_overrun);
            fails++;
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL b2b_drain got v=%b want 0", out_valid); fails++;
        end
    endtask

    task automatic test_abort();
        out_ready = 1'b1;
        start(3'd3);
        for (int i = 0; i < 5; i++) send(10'd100);
        checks++;
        if (win_cnt !== 5'd5) begin
            $display("FAIL abort_partial got cnt=%0d want 5", win_cnt); fails++;
        end
        cfg_en = 1'b0;
        tick();
        send(10'd200);
        checks++;
        if (win_cnt !== 5'd0 || out_valid !== 1'b0) begin
            $display("FAIL abort_idle got cnt=%0d v=%b want cnt=0 v=0",
                     win_cnt, out_valid);
            fails++;
        end
        cfg_en = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) send(10'd8);
        checks++;
        if (win_cnt !== 5'd7 || out_valid !== 1'b0) begin
            $display("FAIL abort_restart got cnt=%0d v=%b want cnt=7 v=0",
                     win_cnt, out_valid);
            fails++;
        end
        send(10'd8);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'd8) begin
            $display("FAIL abort_result got v=%b d=%0d want v=1 d=8",
                     out_valid, out_data);
            fails++;
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        start(3'd1);
        out_ready = 1'b0;
        send(10'd3); send(10'd5);
        send(10'd7); send(10'd9);
        send(10'd1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'd4 ||
            out_overrun !== 1'b1 || win_cnt !== 5'd1) begin
            $display("FAIL rstmid_pre got v=%b d=%0d o=%b cnt=%0d want v=1 d=4 o=1 cnt=1",
                     out_valid, out_data, out_overrun, win_cnt);
            fails++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || win_cnt !== 5'd0 ||
            out_overrun !== 1'b0 || out_data !== 10'd0) begin
            $display("FAIL rstmid_post got v=%b cnt=%0d o=%b d=%0d want all 0",
                     out_valid, win_cnt, out_overrun, out_data);
            fails++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        cfg_en    = 1'b0;
        cfg_log2n = 3'd0;
        sar_valid = 1'b0;
        sar_data  = 10'd0;
        out_ready = 1'b0;
        ovr_clr   = 1'b0;
        test_reset();
        test_passthrough();
        test_round();
        test_clamp_max();
        test_overrun();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
